load_store_unit: RTL



---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory port of the load/store unit.
// The master side is the core together with the memory; the slave side is the LSU.
interface load_store_unit_if;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    modport master (
        output req, is_store, funct3, addr, store_data, mem_RD,
        input  busy, done, load_data, fault, mem_A, mem_WD, mem_WE
    );

    modport slave (
        input  req, is_store, funct3, addr, store_data, mem_RD,
        output busy, done, load_data, fault, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a word-addressed data memory: address checking, load extension,
// and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  lsu
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] word_q, word_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic        legal_f3;
    logic        misaligned;
    logic        out_of_range;
    logic        access_fault;

    // Extracts and extends the addressed lane of a memory word.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            F3Byte:  res = {{24{b[7]}}, b};
            F3Half:  res = {{16{h[15]}}, h};
            F3Word:  res = word;
            F3ByteU: res = {24'h0, b};
            F3HalfU: res = {16'h0, h};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // Builds the word written back: full store data for SW, merged lane for SB/SH.
    function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [31:0] data);
        logic [31:0] res;
        res = word;
        case (f3)
            F3Byte:  res[{lane, 3'b000} +: 8] = data[7:0];
            F3Half:  res[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

    // Fault check on the live inputs of the accept cycle.
    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        if (lsu.is_store) begin
            legal_f3 = (lsu.funct3 <= F3Word);
        end else begin
            legal_f3 = (lsu.funct3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU});
        end
        case (lsu.funct3[1:0])
            2'b01:   misaligned = lsu.addr[0];
            2'b10:   misaligned = (lsu.addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, lsu.addr[31:2]} >= MEM_WORDS);
        access_fault = !legal_f3 || misaligned || out_of_range;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        store_data_d = store_data_q;
        word_d       = word_q;
        load_data_d  = load_data_q;
        fault_d      = fault_q;

        unique case (state_q)
            StIdle: begin
                load_data_d = 32'h0;
                fault_d     = 1'b0;
                if (lsu.req) begin
                    addr_d       = lsu.addr;
                    funct3_d     = lsu.funct3;
                    is_store_d   = lsu.is_store;
                    store_data_d = lsu.store_data;
                    if (access_fault) begin
                        fault_d = 1'b1;
                        state_d = StResp;
                    end else if (lsu.is_store && (lsu.funct3 == F3Word)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                word_d = lsu.mem_RD;
                if (is_store_q) begin
                    state_d = StWrite;
                end else begin
                    load_data_d = extend_load(funct3_q, addr_q[1:0], lsu.mem_RD);
                    state_d     = StResp;
                end
            end
            StWrite: begin
                load_data_d = 32'h0;
                state_d     = StResp;
            end
            StResp: begin
                // The core still presents the same instruction here, so req is ignored.
                load_data_d = 32'h0;
                fault_d     = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= 32'h0;
            funct3_q     <= 3'b000;
            is_store_q   <= 1'b0;
            store_data_q <= 32'h0;
            word_q       <= 32'h0;
            load_data_q  <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            store_data_q <= store_data_d;
            word_q       <= word_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
        end
    end

    // Memory port and handshake outputs decoded from the registered state.
    always_comb begin
        lsu.busy   = 1'b0;
        lsu.mem_A  = 32'h0;
        lsu.mem_WD = 32'h0;
        lsu.mem_WE = 1'b0;
        unique case (state_q)
            StIdle: begin
                lsu.busy = lsu.req & ~rst;
            end
            StRead: begin
                lsu.busy  = 1'b1;
                lsu.mem_A = {2'b00, addr_q[31:2]};
            end
            StWrite: begin
                lsu.busy   = 1'b1;
                lsu.mem_A  = {2'b00, addr_q[31:2]};
                lsu.mem_WE = 1'b1;
                lsu.mem_WD = merge_store(funct3_q, addr_q[1:0], word_q, store_data_q);
            end
            StResp: begin
                lsu.busy = 1'b0;
            end
            default: lsu.busy = 1'b0;
        endcase
    end

    assign lsu.done      = (state_q == StResp);
    assign lsu.load_data = load_data_q;
    assign lsu.fault     = fault_q;

endmodule
